// File: rtl/uart_rx_pkg.sv
// Shared types and defaults for the UART receive path.
// Optional even-parity support is selected with the UART_RX_PARITY_EN macro.
package uart_rx_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 16;
    localparam int DEFAULT_DATA_BITS    = 8;

`ifdef UART_RX_PARITY_EN
    localparam int PARITY_BITS = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;
`else
    localparam int PARITY_BITS = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } rx_state_t;
`endif

endpackage : uart_rx_pkg

// File: rtl/rx_bit_timer.sv
// Bit-period timer: first tick half a bit after arming, then one tick per full bit.
// Held cleared while run is low; the counter wraps to 0 on every sample tick.
module rx_bit_timer
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic sample_tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_count;
    logic          r_first;
    logic [CW-1:0] w_limit;

    // The first interval lands mid start bit; every later one spans a whole bit.
    assign w_limit     = r_first ? HALF_LAST : FULL_LAST;
    assign sample_tick = run && (r_count == w_limit);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            r_count <= '0;
            r_first <= 1'b1;
        end else if (sample_tick) begin
            r_count <= '0;
            r_first <= 1'b0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule : rx_bit_timer

// File: rtl/rx_deserializer.sv
// UART receive deserializer: start/data/stop framing with optional even parity
// (UART_RX_PARITY_EN), one-cycle valid/error pulses and a busy flag.
module rx_deserializer
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 serial_in,
    input  logic                 start_detected,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 framing_error,
    output logic                 parity_error,
    output logic                 busy
);

    localparam int BCW = $clog2(DATA_BITS + 3);
    localparam logic [BCW-1:0] LAST_DATA_CNT = BCW'(DATA_BITS);

`ifdef UART_RX_PARITY_EN
    localparam rx_state_t ST_AFTER_DATA = ST_PARITY;
`else
    localparam rx_state_t ST_AFTER_DATA = ST_STOP;
`endif

    rx_state_t            r_state;
    rx_state_t            w_next_state;
    logic [BCW-1:0]       r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data_out;
    logic                 r_valid;
    logic                 r_ferr;
    logic                 w_sample_tick;
    logic                 w_shift_en;
    logic                 w_frame_end;
    logic                 w_parity_bad;

    rx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk        (clk),
        .reset      (reset),
        .run        (r_state != ST_IDLE),
        .sample_tick(w_sample_tick)
    );

`ifdef UART_RX_PARITY_EN
    logic r_par_bit;
    logic r_perr;
    logic w_par_capture;

    // Even parity: data bits XOR parity bit must come out 0.
    assign w_parity_bad = (^r_shift) ^ r_par_bit;
    assign parity_error = r_perr;
`else
    assign w_parity_bad = 1'b0;
    assign parity_error = 1'b0;
`endif

    // NOTE: every combinational output gets a default before the case so no
    // path leaves a signal unassigned and infers a latch.
    always_comb begin
        w_next_state = r_state;
        w_shift_en   = 1'b0;
        w_frame_end  = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_capture = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (start_detected) w_next_state = ST_START;
            end
            ST_START: begin
                if (w_sample_tick) w_next_state = serial_in ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (w_sample_tick) begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == LAST_DATA_CNT) w_next_state = ST_AFTER_DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (w_sample_tick) begin
                    w_par_capture = 1'b1;
                    w_next_state  = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_sample_tick) begin
                    w_frame_end  = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            // Cleared on the way back to IDLE so it never passes DATA_BITS+2.
            if (w_next_state == ST_IDLE) begin
                r_bit_cnt <= '0;
            end else if (w_sample_tick) begin
                r_bit_cnt <= r_bit_cnt + BCW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift    <= '0;
            r_data_out <= '0;
            r_valid    <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            if (w_shift_en) begin
                r_shift <= {serial_in, r_shift[DATA_BITS-1:1]};
            end
            if (w_frame_end) begin
                r_data_out <= r_shift;
                r_ferr     <= !serial_in;
                r_valid    <= serial_in && !w_parity_bad;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_par_bit <= 1'b0;
            r_perr    <= 1'b0;
        end else begin
            r_perr <= w_frame_end && w_parity_bad;
            if (w_par_capture) r_par_bit <= serial_in;
        end
    end
`endif

    assign data_out      = r_data_out;
    assign data_valid    = r_valid;
    assign framing_error = r_ferr;
    assign busy          = (r_state != ST_IDLE);

endmodule : rx_deserializer

// File: tb/tb_rx_deserializer.sv
// Directed + randomized bench for rx_deserializer; frame outcomes and timings come
// from a frame-level model. Builds with or without UART_RX_PARITY_EN.
module tb_rx_deserializer;
    import uart_rx_pkg::*;

    localparam int C = DEFAULT_CLKS_PER_BIT;
    localparam int D = DEFAULT_DATA_BITS;
`ifdef UART_RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int N = D + 2 + P;

    logic         clk = 1'b0;
    logic         reset;
    logic         serial_in;
    logic         start_detected;
    logic [D-1:0] data_out;
    logic         data_valid;
    logic         framing_error;
    logic         parity_error;
    logic         busy;

    typedef struct {
        int           cyc;
        logic         v;
        logic         fe;
        logic         pe;
        logic [D-1:0] d;
    } ev_t;

    ev_t  ev_q[$];
    logic busy_hist[int];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    rx_deserializer #(
        .CLKS_PER_BIT(C),
        .DATA_BITS   (D)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .serial_in     (serial_in),
        .start_detected(start_detected),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .framing_error (framing_error),
        .parity_error  (parity_error),
        .busy          (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: outputs are sampled 1 time unit after the edge numbered cyc.
    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        busy_hist[cyc] = busy;
        if (data_valid || framing_error || parity_error)
            ev_q.push_back('{cyc, data_valid, framing_error, parity_error, data_out});
    endtask

    task automatic idle(input int n);
        serial_in      = 1'b1;
        start_detected = 1'b0;
        repeat (n) tick();
    endtask

    // Line-level frame: start, data LSB first, optional even parity, stop.
    function automatic logic [11:0] mk(input logic [7:0] d, input logic stop, input logic par_ok);
        logic [11:0]  b;
        logic [D-1:0] dd;
        dd   = d[D-1:0];
        b    = '1;
        b[0] = 1'b0;
        for (int i = 0; i < D; i++) b[1+i] = dd[i];
        if (P == 1) b[D+1] = (^dd) ^ ~par_ok;
        b[D+1+P] = stop;
        return b;
    endfunction

    // Drives a whole frame; the start pulse coincides with the falling edge (t0).
    task automatic drive_line(input logic [11:0] bits, input int rst_at,
                              input bit mid_start, output int t0);
        serial_in      = bits[0];
        start_detected = 1'b1;
        tick();
        t0             = cyc;
        start_detected = 1'b0;
        for (int c = 1; c < N * C; c++) begin
            serial_in      = bits[c / C];
            start_detected = mid_start && (c == 3 * C + 5);
            reset          = (rst_at >= 0) && (c == rst_at);
            tick();
        end
        start_detected = 1'b0;
        reset          = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int idx, input int t0, input logic [11:0] bits);
        logic [D-1:0] d;
        logic         stop;
        logic         pbad;
        int           texp;
        d    = bits[D:1];
        stop = bits[N-1];
        pbad = (P == 1) ? ^bits[D+1:1] : 1'b0;
        texp = t0 + C / 2 + (N - 1) * C;
        chk({tag, " busy@t0"}, busy_hist[t0], 1'b1);
        chk({tag, " busy@stop-1"}, busy_hist[texp-1], 1'b1);
        chk({tag, " busy@stop"}, busy_hist[texp], 1'b0);
        if (ev_q.size() > idx) begin
            chk({tag, " cycle"}, ev_q[idx].cyc - t0, texp - t0);
            chk({tag, " valid"}, ev_q[idx].v, stop && !pbad);
            chk({tag, " ferr"}, ev_q[idx].fe, !stop);
            chk({tag, " perr"}, ev_q[idx].pe, pbad);
            chk({tag, " data"}, ev_q[idx].d, d);
        end
    endtask

    initial begin
        logic [11:0] b, b2;
        int          t0, t1;

        reset          = 1'b1;
        serial_in      = 1'b1;
        start_detected = 1'b0;
        repeat (3) tick();
        chk("rst data_out", data_out, 0);
        chk("rst data_valid", data_valid, 0);
        chk("rst framing_error", framing_error, 0);
        chk("rst parity_error", parity_error, 0);
        chk("rst busy", busy, 0);
        reset = 1'b0;
        idle(5);

        // Reset wins over a simultaneous start pulse.
        reset = 1'b1; start_detected = 1'b1; serial_in = 1'b0;
        tick();
        chk("rst priority busy", busy, 0);
        reset = 1'b0;
        idle(5);
        chk("rst priority still idle", busy, 0);

        ev_q.delete();
        b = mk(8'hA5, 1'b1, 1'b1);
        drive_line(b, -1, 1'b0, t0);
        idle(20);
        chk("a5 count", ev_q.size(), 1);
        check_frame("a5", 0, t0, b);

        // Glitch: line low for only 4 cycles.
        ev_q.delete();
        serial_in = 1'b0; start_detected = 1'b1;
        tick();
        t0 = cyc;
        start_detected = 1'b0;
        repeat (3) tick();
        idle(40);
        chk("glitch count", ev_q.size(), 0);
        chk("glitch busy@t0+7", busy_hist[t0+7], 1'b1);
        chk("glitch busy@t0+8", busy_hist[t0+8], 1'b0);

        ev_q.delete();
        b = mk(8'h3C, 1'b0, 1'b1);
        drive_line(b, -1, 1'b0, t0);
        idle(20);
        chk("badstop count", ev_q.size(), 1);
        check_frame("badstop", 0, t0, b);

        ev_q.delete();
        b  = mk(8'h00, 1'b1, 1'b1);
        b2 = mk(8'hFF, 1'b1, 1'b1);
        drive_line(b, -1, 1'b0, t0);
        drive_line(b2, -1, 1'b0, t1);
        idle(20);
        chk("b2b count", ev_q.size(), 2);
        check_frame("b2b first", 0, t0, b);
        check_frame("b2b second", 1, t1, b2);
        if (ev_q.size() >= 2) chk("b2b spacing", ev_q[1].cyc - ev_q[0].cyc, N * C);

        // Reset mid-frame: partial frame discarded, line keeps toggling.
        ev_q.delete();
        b = mk(8'($urandom), 1'b1, 1'b1);
        drive_line(b, 60, 1'b0, t0);
        chk("midrst busy@t0+59", busy_hist[t0+59], 1'b1);
        chk("midrst busy@t0+60", busy_hist[t0+60], 1'b0);
        chk("midrst data_out", data_out, 0);
        idle(20);
        chk("midrst count", ev_q.size(), 0);
        chk("midrst busy", busy, 0);
        b = mk(8'h5A, 1'b1, 1'b1);
        drive_line(b, -1, 1'b0, t0);
        idle(20);
        chk("after rst count", ev_q.size(), 1);
        check_frame("after rst 5a", 0, t0, b);

        // A start pulse in the middle of a frame must be ignored.
        ev_q.delete();
        b = mk(8'($urandom), 1'b1, 1'b1);
        drive_line(b, -1, 1'b1, t0);
        idle(20);
        chk("midstart count", ev_q.size(), 1);
        check_frame("midstart", 0, t0, b);

`ifdef UART_RX_PARITY_EN
        ev_q.delete();
        b = mk(8'h07, 1'b1, 1'b0);
        drive_line(b, -1, 1'b0, t0);
        idle(20);
        chk("par0 count", ev_q.size(), 1);
        check_frame("par0", 0, t0, b);

        ev_q.delete();
        b = mk(8'h07, 1'b1, 1'b1);
        drive_line(b, -1, 1'b0, t0);
        idle(20);
        chk("par1 count", ev_q.size(), 1);
        check_frame("par1", 0, t0, b);

        ev_q.delete();
        b = mk(8'($urandom), 1'b0, 1'b0);
        drive_line(b, -1, 1'b0, t0);
        idle(20);
        chk("par+stop count", ev_q.size(), 1);
        check_frame("par+stop", 0, t0, b);
`endif

        for (int i = 0; i < 8; i++) begin
            logic stop;
            logic pok;
            stop = ($urandom_range(0, 3) != 0);
            pok  = (P == 0) || ($urandom_range(0, 3) != 0);
            ev_q.delete();
            b = mk(8'($urandom), stop, pok);
            drive_line(b, -1, 1'b0, t0);
            idle($urandom_range(1, 20));
            chk("rand count", ev_q.size(), 1);
            check_frame("rand", 0, t0, b);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_rx_deserializer
